sobel_window_gen: RTL
=====================

// Module: sobel_window_gen
// PURPOSE
//  Raster-stream front end for the Sobel pipeline. Accepts one 8-bit pixel per handshake in raster order.
//  Two on-chip line buffers plus a 3x3 shift window build the neighbourhood of every interior pixel.
//  Emits one registered 3x3 window per interior pixel, feeding a single sobel_pixel_mask downstream.
//  Border pixels get no window; the consumer writes 8'h00 for them.
// PARAMETERS
//  WIDTH_P   10  pixels per row (x, fastest-varying); legal range >= 3
//  HEIGHT_P  10  rows per frame (y); legal range >= 3
//  XW = $clog2(WIDTH_P), YW = $clog2(HEIGHT_P)  (localparams, not overridable)
// PORTS
//  clk_i         in   1   clock; all state updates on rising edge
//  reset_ni      in   1   asynchronous active-low reset
//  pixel_i       in   8   input pixel
//  valid_i       in   1   pixel_i valid
//  ready_o       out  1   block accepts pixel_i this cycle
//  p0_o..p8_o    out  8   window; p0=(cx-1,cy-1) p1=(cx,cy-1) p2=(cx+1,cy-1) p3=(cx-1,cy) p4=(cx,cy)
//                         p5=(cx+1,cy) p6=(cx-1,cy+1) p7=(cx,cy+1) p8=(cx+1,cy+1)
//  cx_o          out  XW  window centre x
//  cy_o          out  YW  window centre y
//  last_o        out  1   window is the frame's final one (cx=WIDTH_P-2, cy=HEIGHT_P-2)
//  valid_o       out  1   window outputs valid
//  ready_i       in   1   downstream accepts the window
// BEHAVIOUR
//  Input handshake: pixel accepted when valid_i && ready_o. Output handshake: window consumed when valid_o && ready_i.
//  ready_o = !valid_o || ready_i: one output register, combinational back-pressure, no bubble at full rate.
//  Counters: x_r (0..WIDTH_P-1) increments per accept. At WIDTH_P-1, x_r wraps to 0 and y_r increments.
//   At (WIDTH_P-1, HEIGHT_P-1), both wrap to 0 and the next accept starts a new frame.
//  On accept at (x,y): column {t,m,b} = {lb1[x], lb0[x], pixel_i}; lb1[x] <= lb0[x]; lb0[x] <= pixel_i.
//   The 3x3 window shifts left by one column, and {t,m,b} enters as the right column.
//  Emit rule: an accept with x>=2 && y>=2 loads the output registers in the same edge.
//   Loaded values: the post-shift window, cx=x-1, cy=y-1, last=(x==WIDTH_P-1 && y==HEIGHT_P-1); valid_o set.
//  Other accepts (x<2 or y<2): load nothing; valid_o cleared if it was consumed this cycle.
//  Latency: window for centre (cx,cy) valid on the cycle after pixel (cx+1,cy+1) is accepted.
//  Simultaneous consume + new emit in one cycle: output registers overwritten, valid_o stays 1.
//  Consume with no new emit: valid_o <= 0.
//  While valid_o && !ready_i: all outputs hold stable, ready_o=0, no counter/buffer/window change.
//  Window count per frame = (WIDTH_P-2)*(HEIGHT_P-2), emitted in raster order of centre.
//  Reset (async assert, any time incl. mid-frame): x_r=0, y_r=0, valid_o=0, last_o=0, cx_o=0, cy_o=0, p*_o=0.
//   Line buffers and the shift window are not reset; their stale data is never emitted because y>=2 and x>=2 gate emission.
//   The first frame after reset starts at (0,0).
//  Frame-to-frame: row 0/1 of a new frame never pair with old-frame rows (y>=2 gate), no flush needed.
//  Arithmetic: counters compare against WIDTH_P-1/HEIGHT_P-1 exactly; no saturation, no pixel arithmetic.
// CONFIGURATION
//  SOBEL_WIN_FRAME_CNT_EN defined:
//   adds output frame_cnt_o [15:0], reset 0.
//   Increments when the last_o window is consumed (valid_o && ready_i && last_o), wrapping 16'hFFFF->0.
//  Not defined: port absent, no counter logic; all other behaviour identical.
// TESTING
//  1. Defaults, pixel(x,y)=10*y+x, valid_i=1, ready_i=1 -> 64 windows.
//     First window: cx=1, cy=1, p0..p8 = 0,1,2,10,11,12,20,21,22.
//     That window's valid_o rises the cycle after pixel (2,2)=22 is accepted. Last: cx=8, cy=8, last_o=1.
//  2. Same stream, ready_i toggling 1/0 each cycle -> identical 64-window sequence.
//     Outputs hold stable while stalled; ready_o=0 whenever valid_o && !ready_i.
//  3. Random valid_i gaps (50%) -> same 64 windows in the same order; no window dropped or duplicated.
//  4. Two back-to-back frames, frame 2 pixel = frame 1 pixel + 100.
//     Frame 2's first window = 100,101,102,110,111,112,120,121,122, with no mixing across frames.
//  5. Assert reset_ni at pixel (5,4) mid-frame -> valid_o=0 immediately.
//     A fresh frame then yields 64 correct windows starting at cx=1, cy=1.
//  6. WIDTH_P=3, HEIGHT_P=3, pixels 1..9 -> exactly one window p0..p8 = 1..9 with last_o=1.
//     With SOBEL_WIN_FRAME_CNT_EN, frame_cnt_o goes 0->1 on its consumption.

Source files
------------

// File: rtl/sobel_window_gen.sv
// Raster-stream 3x3 window generator: two line buffers and a shift window, one registered window per interior pixel.
// Optional SOBEL_WIN_FRAME_CNT_EN adds frame_cnt_o, counting consumed final windows.
module sobel_window_gen #(
  parameter  int WIDTH_P  = 10,
  parameter  int HEIGHT_P = 10,
  localparam int XW = $clog2(WIDTH_P),
  localparam int YW = $clog2(HEIGHT_P)
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic [7:0]    pixel_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic [7:0]    p0_o,
  output logic [7:0]    p1_o,
  output logic [7:0]    p2_o,
  output logic [7:0]    p3_o,
  output logic [7:0]    p4_o,
  output logic [7:0]    p5_o,
  output logic [7:0]    p6_o,
  output logic [7:0]    p7_o,
  output logic [7:0]    p8_o,
  output logic [XW-1:0] cx_o,
  output logic [YW-1:0] cy_o,
  output logic          last_o,
  output logic          valid_o,
`ifdef SOBEL_WIN_FRAME_CNT_EN
  output logic [15:0]   frame_cnt_o,
`endif
  input  logic          ready_i
);

  logic [XW-1:0]        x_q, x_d, cx_q;
  logic [YW-1:0]        y_q, y_d, cy_q;
  logic [7:0]           lb0_q [WIDTH_P];
  logic [7:0]           lb1_q [WIDTH_P];
  logic [2:0][2:0][7:0] win_q;   // [row][col], col 0 is leftmost
  logic [2:0][7:0]      col;
  logic [8:0][7:0]      p_q, p_d;
  logic                 valid_q, last_q;
  logic                 accept, emit, x_end, y_end;

  assign ready_o = !valid_q || ready_i;
  assign accept  = valid_i && ready_o;
  assign x_end   = (x_q == XW'(WIDTH_P - 1));
  assign y_end   = (y_q == YW'(HEIGHT_P - 1));
  assign emit    = accept && (x_q >= XW'(2)) && (y_q >= YW'(2));

  always_comb begin
    col[0] = lb1_q[x_q];
    col[1] = lb0_q[x_q];
    col[2] = pixel_i;
    x_d    = x_end ? '0 : x_q + 1'b1;
    y_d    = y_q;
    if (x_end) y_d = y_end ? '0 : y_q + 1'b1;
    // Window as it will look after this accept's shift.
    p_d = '0;
    for (int r = 0; r < 3; r++) begin
      p_d[3*r]   = win_q[r][1];
      p_d[3*r+1] = win_q[r][2];
      p_d[3*r+2] = col[r];
    end
  end

  // Line buffers and shift window carry no reset; the x/y emit gate hides stale contents.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb1_q[x_q] <= lb0_q[x_q];
      lb0_q[x_q] <= pixel_i;
      for (int r = 0; r < 3; r++) win_q[r] <= {col[r], win_q[r][2], win_q[r][1]};
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      p_q     <= '0;
    end else begin
      if (accept) begin
        x_q <= x_d;
        y_q <= y_d;
      end
      if (emit) begin
        valid_q <= 1'b1;
        p_q     <= p_d;
        cx_q    <= x_q - 1'b1;
        cy_q    <= y_q - 1'b1;
        last_q  <= x_end && y_end;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef SOBEL_WIN_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) frame_cnt_q <= '0;
    else if (valid_q && ready_i && last_q) frame_cnt_q <= frame_cnt_q + 16'd1;
  end
  assign frame_cnt_o = frame_cnt_q;
`endif

  assign {p8_o, p7_o, p6_o, p5_o, p4_o, p3_o, p2_o, p1_o, p0_o} = p_q;
  assign cx_o    = cx_q;
  assign cy_o    = cy_q;
  assign last_o  = last_q;
  assign valid_o = valid_q;

endmodule
